// File: rtl/axi_pkg.sv
// rtl/axi_pkg.sv - shared AXI response encodings
package axi_pkg;

  typedef logic [1:0] resp_t;

  localparam resp_t RESP_OKAY   = 2'b00;
  localparam resp_t RESP_EXOKAY = 2'b01;
  localparam resp_t RESP_SLVERR = 2'b10;
  localparam resp_t RESP_DECERR = 2'b11;

endpackage

// File: rtl/axi_rt_reg_to_axi_lite.sv
// rtl/axi_rt_reg_to_axi_lite.sv - reg-bus to AXI-Lite manager bridge with timeout guard
module axi_rt_reg_to_axi_lite
  import axi_pkg::*;
#(
  parameter int unsigned AddrWidth     = 32,
  parameter int unsigned DataWidth     = 32,
  parameter int unsigned TimeoutCycles = 1024,
  parameter logic [2:0]  ProtValue     = 3'b000
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   reg_valid_i,
  input  logic                   reg_write_i,
  input  logic [AddrWidth-1:0]   reg_addr_i,
  input  logic [DataWidth-1:0]   reg_wdata_i,
  input  logic [DataWidth/8-1:0] reg_wstrb_i,
  output logic                   reg_ready_o,
  output logic [DataWidth-1:0]   reg_rdata_o,
  output logic                   reg_error_o,
  output logic [AddrWidth-1:0]   m_axi_lite_awaddr_o,
  output logic [2:0]             m_axi_lite_awprot_o,
  output logic                   m_axi_lite_awvalid_o,
  input  logic                   m_axi_lite_awready_i,
  output logic [DataWidth-1:0]   m_axi_lite_wdata_o,
  output logic [DataWidth/8-1:0] m_axi_lite_wstrb_o,
  output logic                   m_axi_lite_wvalid_o,
  input  logic                   m_axi_lite_wready_i,
  input  logic [1:0]             m_axi_lite_bresp_i,
  input  logic                   m_axi_lite_bvalid_i,
  output logic                   m_axi_lite_bready_o,
  output logic [AddrWidth-1:0]   m_axi_lite_araddr_o,
  output logic [2:0]             m_axi_lite_arprot_o,
  output logic                   m_axi_lite_arvalid_o,
  input  logic                   m_axi_lite_arready_i,
  input  logic [DataWidth-1:0]   m_axi_lite_rdata_i,
  input  logic [1:0]             m_axi_lite_rresp_i,
  input  logic                   m_axi_lite_rvalid_i,
  output logic                   m_axi_lite_rready_o
);

  localparam int unsigned StrbWidth = DataWidth / 8;
  localparam int unsigned CntWidth  = (TimeoutCycles > 0) ? $clog2(TimeoutCycles + 1) : 1;

  typedef enum logic [2:0] {IDLE, WRITE, WAIT_B, READ, WAIT_R, RESP, DRAIN} state_e;

  state_e                 state_q, state_d;
  logic                   write_q, write_d;
  logic [AddrWidth-1:0]   addr_q, addr_d;
  logic [DataWidth-1:0]   wdata_q, wdata_d;
  logic [StrbWidth-1:0]   wstrb_q, wstrb_d;
  logic                   awvalid_q, awvalid_d;
  logic                   wvalid_q, wvalid_d;
  logic                   arvalid_q, arvalid_d;
  logic                   bready_q, bready_d;
  logic                   rready_q, rready_d;
  logic                   aw_done_q, aw_done_d;
  logic                   w_done_q, w_done_d;
  logic                   ready_q, ready_d;
  logic                   error_q, error_d;
  logic [DataWidth-1:0]   rdata_q, rdata_d;
  logic [CntWidth-1:0]    cnt_q, cnt_d;

  logic aw_hs, w_hs, ar_hs, b_hs, r_hs;
  logic aw_done_n, w_done_n, timeout_hit;

  function automatic logic resp_is_err(input resp_t resp);
    return (resp == RESP_SLVERR) || (resp == RESP_DECERR);
  endfunction

  assign aw_hs     = awvalid_q && m_axi_lite_awready_i;
  assign w_hs      = wvalid_q && m_axi_lite_wready_i;
  assign ar_hs     = arvalid_q && m_axi_lite_arready_i;
  assign b_hs      = bready_q && m_axi_lite_bvalid_i;
  assign r_hs      = rready_q && m_axi_lite_rvalid_i;
  assign aw_done_n = aw_done_q || aw_hs;
  assign w_done_n  = w_done_q || w_hs;

  // Fires one cycle early so the registered error pulse lands TimeoutCycles after accept.
  assign timeout_hit = (TimeoutCycles != 0) && ((32'(cnt_q) + 32'd2) >= TimeoutCycles);

  always_comb begin
    state_d   = state_q;
    write_d   = write_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    awvalid_d = awvalid_q;
    wvalid_d  = wvalid_q;
    arvalid_d = arvalid_q;
    bready_d  = bready_q;
    rready_d  = rready_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    cnt_d     = cnt_q;
    ready_d   = 1'b0;
    error_d   = 1'b0;
    rdata_d   = '0;
    unique case (state_q)
      IDLE: begin
        if (reg_valid_i) begin
          write_d   = reg_write_i;
          addr_d    = reg_addr_i;
          wdata_d   = reg_wdata_i;
          wstrb_d   = reg_wstrb_i;
          cnt_d     = '0;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          if (reg_write_i) begin
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            state_d   = WRITE;
          end else begin
            arvalid_d = 1'b1;
            state_d   = READ;
          end
        end
      end
      WRITE: begin
        cnt_d     = cnt_q + CntWidth'(1);
        aw_done_d = aw_done_n;
        w_done_d  = w_done_n;
        awvalid_d = !aw_done_n;
        wvalid_d  = !w_done_n;
        bready_d  = aw_done_n && w_done_n;
        if (timeout_hit) begin
          ready_d = 1'b1;
          error_d = 1'b1;
          state_d = DRAIN;
        end else if (aw_done_n && w_done_n) begin
          state_d = WAIT_B;
        end
      end
      WAIT_B: begin
        cnt_d = cnt_q + CntWidth'(1);
        if (b_hs) begin
          bready_d = 1'b0;
          ready_d  = 1'b1;
          error_d  = resp_is_err(m_axi_lite_bresp_i);
          state_d  = RESP;
        end else if (timeout_hit) begin
          ready_d = 1'b1;
          error_d = 1'b1;
          state_d = DRAIN;
        end
      end
      READ: begin
        cnt_d     = cnt_q + CntWidth'(1);
        arvalid_d = arvalid_q && !m_axi_lite_arready_i;
        rready_d  = ar_hs;
        if (timeout_hit) begin
          ready_d = 1'b1;
          error_d = 1'b1;
          state_d = DRAIN;
        end else if (ar_hs) begin
          state_d = WAIT_R;
        end
      end
      WAIT_R: begin
        cnt_d = cnt_q + CntWidth'(1);
        if (r_hs) begin
          rready_d = 1'b0;
          ready_d  = 1'b1;
          error_d  = resp_is_err(m_axi_lite_rresp_i);
          rdata_d  = m_axi_lite_rdata_i;
          state_d  = RESP;
        end else if (timeout_hit) begin
          ready_d = 1'b1;
          error_d = 1'b1;
          state_d = DRAIN;
        end
      end
      RESP: state_d = IDLE;
      DRAIN: begin
        // Finish the abandoned transaction so the subordinate never sees a dropped valid.
        if (write_q) begin
          aw_done_d = aw_done_n;
          w_done_d  = w_done_n;
          awvalid_d = !aw_done_n;
          wvalid_d  = !w_done_n;
          if (b_hs) begin
            bready_d = 1'b0;
            state_d  = IDLE;
          end else begin
            bready_d = aw_done_n && w_done_n;
          end
        end else begin
          arvalid_d = arvalid_q && !m_axi_lite_arready_i;
          if (r_hs) begin
            rready_d = 1'b0;
            state_d  = IDLE;
          end else begin
            rready_d = rready_q || ar_hs;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      write_q   <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      arvalid_q <= 1'b0;
      bready_q  <= 1'b0;
      rready_q  <= 1'b0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      ready_q   <= 1'b0;
      error_q   <= 1'b0;
      rdata_q   <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      write_q   <= write_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      awvalid_q <= awvalid_d;
      wvalid_q  <= wvalid_d;
      arvalid_q <= arvalid_d;
      bready_q  <= bready_d;
      rready_q  <= rready_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
      ready_q   <= ready_d;
      error_q   <= error_d;
      rdata_q   <= rdata_d;
      cnt_q     <= cnt_d;
    end
  end

  assign reg_ready_o          = ready_q;
  assign reg_rdata_o          = rdata_q;
  assign reg_error_o          = error_q;
  assign m_axi_lite_awaddr_o  = addr_q;
  assign m_axi_lite_awprot_o  = ProtValue;
  assign m_axi_lite_awvalid_o = awvalid_q;
  assign m_axi_lite_wdata_o   = wdata_q;
  assign m_axi_lite_wstrb_o   = wstrb_q;
  assign m_axi_lite_wvalid_o  = wvalid_q;
  assign m_axi_lite_bready_o  = bready_q;
  assign m_axi_lite_araddr_o  = addr_q;
  assign m_axi_lite_arprot_o  = ProtValue;
  assign m_axi_lite_arvalid_o = arvalid_q;
  assign m_axi_lite_rready_o  = rready_q;

endmodule

// File: tb/tb_axi_rt_reg_to_axi_lite.sv
// tb/tb_axi_rt_reg_to_axi_lite.sv - bench for the reg-bus to AXI-Lite bridge
module tb_axi_rt_reg_to_axi_lite;
  import axi_pkg::*;

  localparam int TO = 8;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        reg_valid_i, reg_write_i;
  logic [31:0] reg_addr_i, reg_wdata_i;
  logic [3:0]  reg_wstrb_i;
  logic        reg_ready_o, reg_error_o;
  logic [31:0] reg_rdata_o;
  logic [31:0] awaddr, wdata, araddr, rdata;
  logic [2:0]  awprot, arprot;
  logic [3:0]  wstrb;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [1:0]  bresp, rresp;

  axi_rt_reg_to_axi_lite #(.AddrWidth(32), .DataWidth(32), .TimeoutCycles(TO), .ProtValue(3'b000)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .reg_valid_i(reg_valid_i), .reg_write_i(reg_write_i), .reg_addr_i(reg_addr_i),
    .reg_wdata_i(reg_wdata_i), .reg_wstrb_i(reg_wstrb_i),
    .reg_ready_o(reg_ready_o), .reg_rdata_o(reg_rdata_o), .reg_error_o(reg_error_o),
    .m_axi_lite_awaddr_o(awaddr), .m_axi_lite_awprot_o(awprot), .m_axi_lite_awvalid_o(awvalid),
    .m_axi_lite_awready_i(awready),
    .m_axi_lite_wdata_o(wdata), .m_axi_lite_wstrb_o(wstrb), .m_axi_lite_wvalid_o(wvalid),
    .m_axi_lite_wready_i(wready),
    .m_axi_lite_bresp_i(bresp), .m_axi_lite_bvalid_i(bvalid), .m_axi_lite_bready_o(bready),
    .m_axi_lite_araddr_o(araddr), .m_axi_lite_arprot_o(arprot), .m_axi_lite_arvalid_o(arvalid),
    .m_axi_lite_arready_i(arready),
    .m_axi_lite_rdata_i(rdata), .m_axi_lite_rresp_i(rresp), .m_axi_lite_rvalid_i(rvalid),
    .m_axi_lite_rready_o(rready)
  );

  initial forever #5 clk_i = ~clk_i;

  typedef struct {
    bit          wr;
    logic [31:0] addr, wdata;
    logic [3:0]  wstrb;
    int          aw_d, w_d, ar_d, rsp_d;
    logic [1:0]  resp;
    logic [31:0] rdata;
    int          exp_k;
    bit          exp_err;
    logic [31:0] exp_rdata;
  } vec_t;

  int total = 0, bad = 0, cyc = 0, idle_cyc = 0;

  // subordinate configuration and state
  int          cfg_aw_d, cfg_w_d, cfg_ar_d, cfg_rsp_d;
  logic [1:0]  cfg_resp;
  logic [31:0] cfg_rdata;
  int          aw_age, w_age, ar_age, b_left, r_left, viol;
  bit          aw_got, w_got, b_pend, r_pend, b_hs, r_hs, aw_pp, w_pp, ar_pp;
  logic [1:0]  b_resp_p, r_resp_p;
  logic [31:0] r_data_p, cap_awaddr, cap_wdata, cap_araddr;
  logic [3:0]  cap_wstrb;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  initial forever begin
    @(posedge clk_i);
    cyc++;
  end

  // Zero-state subordinate: readies after a programmed wait, responses a programmed delay after the address phase.
  initial begin
    viol = 0;
    forever begin
      @(negedge clk_i);
      if (!rst_ni) begin
        awready = 0; wready = 0; arready = 0; bvalid = 0; rvalid = 0;
        bresp = 0; rresp = 0; rdata = 0;
        aw_age = 0; w_age = 0; ar_age = 0; aw_got = 0; w_got = 0;
        b_pend = 0; r_pend = 0; b_hs = 0; r_hs = 0; aw_pp = 0; w_pp = 0; ar_pp = 0;
      end else begin
        if ((aw_pp && !awvalid) || (w_pp && !wvalid) || (ar_pp && !arvalid)) viol++;
        if (b_hs) begin bvalid = 0; b_hs = 0; end
        if (r_hs) begin rvalid = 0; r_hs = 0; end
        if (b_pend) begin
          if (b_left == 0) begin bvalid = 1; bresp = b_resp_p; b_pend = 0; end
          else b_left--;
        end
        if (r_pend) begin
          if (r_left == 0) begin rvalid = 1; rresp = r_resp_p; rdata = r_data_p; r_pend = 0; end
          else r_left--;
        end
        awready = awvalid && (aw_age >= cfg_aw_d);
        wready  = wvalid && (w_age >= cfg_w_d);
        arready = arvalid && (ar_age >= cfg_ar_d);
        aw_pp = awvalid && !awready;
        w_pp  = wvalid && !wready;
        ar_pp = arvalid && !arready;
        if (awvalid) begin
          if (awready) begin aw_age = 0; aw_got = 1; cap_awaddr = awaddr; end
          else aw_age++;
        end
        if (wvalid) begin
          if (wready) begin w_age = 0; w_got = 1; cap_wdata = wdata; cap_wstrb = wstrb; end
          else w_age++;
        end
        if (arvalid) begin
          if (arready) begin
            ar_age = 0; cap_araddr = araddr;
            r_pend = 1; r_left = cfg_rsp_d; r_resp_p = cfg_resp; r_data_p = cfg_rdata;
          end else ar_age++;
        end
        if (aw_got && w_got) begin
          aw_got = 0; w_got = 0;
          b_pend = 1; b_left = cfg_rsp_d; b_resp_p = cfg_resp;
        end
        if (bvalid && bready) b_hs = 1;
        if (rvalid && rready) r_hs = 1;
      end
    end
  end

  function automatic vec_t mk(input bit wr, input logic [31:0] addr, input logic [31:0] wd,
                              input logic [3:0] ws, input int awd, input int wdl, input int ard,
                              input int rspd, input logic [1:0] resp, input logic [31:0] rd,
                              input int ek, input bit ee, input logic [31:0] er);
    vec_t v;
    v.wr = wr; v.addr = addr; v.wdata = wd; v.wstrb = ws;
    v.aw_d = awd; v.w_d = wdl; v.ar_d = ard; v.rsp_d = rspd;
    v.resp = resp; v.rdata = rd; v.exp_k = ek; v.exp_err = ee; v.exp_rdata = er;
    return v;
  endfunction

  // Cycle after accept on which a normal (untimed) completion would pulse ready.
  function automatic int normal_cyc(input vec_t v);
    int addr_phase;
    addr_phase = v.wr ? ((v.aw_d > v.w_d) ? v.aw_d : v.w_d) : v.ar_d;
    return addr_phase + 3 + v.rsp_d;
  endfunction

  function automatic vec_t predict(input vec_t v);
    vec_t r;
    int   n;
    r = v;
    n = normal_cyc(v);
    if (n <= TO) begin
      r.exp_k     = n;
      r.exp_err   = (v.resp == RESP_SLVERR) || (v.resp == RESP_DECERR);
      r.exp_rdata = v.wr ? 32'h0 : v.rdata;
    end else begin
      r.exp_k = TO; r.exp_err = 1'b1; r.exp_rdata = 32'h0;
    end
    return r;
  endfunction

  task automatic set_and_drive(input vec_t v);
    cfg_aw_d = v.aw_d; cfg_w_d = v.w_d; cfg_ar_d = v.ar_d; cfg_rsp_d = v.rsp_d;
    cfg_resp = v.resp; cfg_rdata = v.rdata;
    reg_valid_i = 1; reg_write_i = v.wr; reg_addr_i = v.addr;
    reg_wdata_i = v.wdata; reg_wstrb_i = v.wstrb;
  endtask

  task automatic run(input string tag, input vec_t v);
    int c, a, k, n, exp_a;
    bit found;
    set_and_drive(v);
    c = cyc;
    exp_a = (c > idle_cyc) ? c : idle_cyc;
    found = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk_i);
      if (awvalid || arvalid) begin found = 1; break; end
    end
    a = cyc - 1;
    chk({tag, ".accept"}, found ? 64'(a) : 64'hdead, 64'(exp_a));
    if (!found) begin reg_valid_i = 0; return; end
    found = 0;
    for (int i = 0; i < 100; i++) begin
      if (reg_ready_o) begin found = 1; break; end
      @(negedge clk_i);
    end
    k = cyc - a;
    reg_valid_i = 0;
    chk({tag, ".latency"}, found ? 64'(k) : 64'hdead, 64'(v.exp_k));
    chk({tag, ".error"}, 64'(reg_error_o), 64'(v.exp_err));
    chk({tag, ".rdata"}, 64'(reg_rdata_o), 64'(v.exp_rdata));
    n = normal_cyc(v);
    if (n <= TO) begin
      if (v.wr) begin
        chk({tag, ".awaddr"}, 64'(cap_awaddr), 64'(v.addr));
        chk({tag, ".wdata"}, 64'(cap_wdata), 64'(v.wdata));
        chk({tag, ".wstrb"}, 64'(cap_wstrb), 64'(v.wstrb));
      end else begin
        chk({tag, ".araddr"}, 64'(cap_araddr), 64'(v.addr));
      end
      idle_cyc = a + n + 1;
    end else begin
      idle_cyc = a + n;
    end
    @(negedge clk_i);
    chk({tag, ".ready_one_cycle"}, 64'(reg_ready_o), 64'h0);
  endtask

  function automatic logic [255:0] all_outs();
    return {reg_ready_o, reg_rdata_o, reg_error_o, awaddr, awvalid, wdata, wstrb, wvalid,
            bready, araddr, arvalid, rready};
  endfunction

  vec_t tbl[8];
  vec_t v;

  initial begin
    rst_ni = 0; reg_valid_i = 0; reg_write_i = 0; reg_addr_i = 0; reg_wdata_i = 0; reg_wstrb_i = 0;
    cfg_aw_d = 0; cfg_w_d = 0; cfg_ar_d = 0; cfg_rsp_d = 0; cfg_resp = 0; cfg_rdata = 0;

    tbl[0] = mk(1, 32'h10, 32'hDEADBEEF, 4'hF, 0, 0, 0, 0,  RESP_OKAY,   32'h0,        3, 0, 32'h0);
    tbl[1] = mk(0, 32'h24, 32'h0,        4'h0, 0, 0, 4, 0,  RESP_OKAY,   32'h12345678, 7, 0, 32'h12345678);
    tbl[2] = mk(1, 32'h30, 32'hCAFEF00D, 4'h3, 3, 0, 0, 0,  RESP_SLVERR, 32'h0,        6, 1, 32'h0);
    tbl[3] = mk(0, 32'h40, 32'h0,        4'h0, 0, 0, 0, 0,  RESP_DECERR, 32'hAAAA5555, 3, 1, 32'hAAAA5555);
    tbl[4] = mk(1, 32'h44, 32'h01020304, 4'h8, 0, 0, 0, 2,  RESP_EXOKAY, 32'h0,        5, 0, 32'h0);
    tbl[5] = mk(1, 32'h50, 32'h55AA55AA, 4'hF, 0, 0, 0, 18, RESP_OKAY,   32'h0,        8, 1, 32'h0);
    tbl[6] = mk(0, 32'h60, 32'h0,        4'h0, 0, 0, 0, 5,  RESP_OKAY,   32'h0BADCAFE, 8, 0, 32'h0BADCAFE);
    tbl[7] = mk(0, 32'h64, 32'h0,        4'h0, 0, 0, 0, 6,  RESP_SLVERR, 32'h77777777, 8, 1, 32'h0);

    repeat (3) @(negedge clk_i);
    chk("reset_outputs", 64'(all_outs() != 0), 64'h0);
    rst_ni = 1;
    @(negedge clk_i);
    idle_cyc = cyc;

    for (int i = 0; i < 8; i++) run($sformatf("tbl%0d", i), tbl[i]);

    // async reset while waiting on R
    v = mk(0, 32'h68, 32'h0, 4'h0, 0, 0, 0, 10, RESP_OKAY, 32'hFFFF0000, 0, 0, 32'h0);
    set_and_drive(v);
    @(negedge clk_i);
    @(negedge clk_i);
    chk("pre_reset_rready", 64'(rready), 64'h1);
    #2 rst_ni = 0;
    #1 chk("async_reset_outputs", 64'(all_outs() != 0), 64'h0);
    reg_valid_i = 0;
    @(negedge clk_i);
    @(negedge clk_i);
    #2 rst_ni = 1;
    @(negedge clk_i);
    idle_cyc = cyc;
    run("post_reset_read", mk(0, 32'h70, 32'h0, 4'h0, 0, 0, 0, 0, RESP_OKAY, 32'h13579BDF,
                              3, 0, 32'h13579BDF));

    for (int i = 0; i < 40; i++) begin
      v = mk($urandom_range(0, 1), $urandom & 32'hFFFC, $urandom, 4'($urandom_range(0, 15)),
             $urandom_range(0, 4), $urandom_range(0, 4), $urandom_range(0, 4), $urandom_range(0, 7),
             2'($urandom_range(0, 3)), $urandom, 0, 0, 32'h0);
      run($sformatf("rnd%0d", i), predict(v));
    end

    chk("valid_held_until_handshake", 64'(viol), 64'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
